// File: rtl/branch_predictor_pkg.sv
// Shared types for the branch predictor: PHT state encodings, default table size
// and the pipeline stage-entry record carried from D through M.
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } pht_state_e;

  localparam int INDEX_W_DEF = 6;
  // Stage entries carry the index at a fixed width so one record type serves any INDEX_W.
  localparam int IDX_MAX_W = 16;

  typedef struct packed {
    logic                 valid;
    logic                 pred;
    logic [IDX_MAX_W-1:0] idx;
  } stage_entry_t;

endpackage

// File: rtl/branch_predictor_floprc.sv
// Pipeline register with enable and synchronous clear; clear wins over enable.
module floprc #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= d;
  end

endmodule

// File: rtl/branch_predictor_sat_counter2.sv
// One PHT entry: a 2-bit saturating up/down counter, reset to weakly not-taken.
module sat_counter2
  import branch_predictor_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       upd,
  input  logic       taken,
  output pht_state_e state
);

  pht_state_e state_nxt;

  always_comb begin
    state_nxt = state;
    if (taken) begin
      if (state != ST) state_nxt = pht_state_e'(state + 2'b01);
    end else begin
      if (state != SNT) state_nxt = pht_state_e'(state - 2'b01);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     state <= WNT;
    else if (upd) state <= state_nxt;
  end

endmodule

// File: rtl/branch_predictor.sv
// Bimodal branch predictor: 2-bit PHT read in D, carried through E to M, trained in M,
// with retired-branch and misprediction counters.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int INDEX_W = INDEX_W_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pcF,
  input  logic        stallD,
  input  logic        branchD,
  input  logic        actual_takeM,
  output logic        pred_takeD,
  output logic        pred_takeM,
  output logic        branchM,
  output logic        mispredictM,
  output logic [15:0] branch_cnt,
  output logic [15:0] mispred_cnt
);

  localparam int PHT_N = 1 << INDEX_W;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [INDEX_W-1:0] idx_f;
  logic [INDEX_W-1:0] idx_p0;
  logic [INDEX_W-1:0] idx_m;
  stage_entry_t       ent_p0;
  stage_entry_t       ent_p1;
  stage_entry_t       ent_p2;
  pht_state_e         pht_q [PHT_N];
  logic               unused_bits;

  assign idx_f = pcF[INDEX_W+1:2];

  // F -> D: index of the instruction now in decode
  floprc #(.W(INDEX_W)) u_fd (
    .clk (clk),
    .rst (rst),
    .en  (~stallD),
    .clr (mispredictM),
    .d   (idx_f),
    .q   (idx_p0)
  );

  // Read returns the pre-update value even when M trains the same entry this cycle.
  assign pred_takeD = branchD & ((pht_q[idx_p0] == WT) || (pht_q[idx_p0] == ST));
  assign ent_p0     = '{valid: branchD, pred: pred_takeD, idx: IDX_MAX_W'(idx_p0)};

  // D -> E
  floprc #(.W($bits(stage_entry_t))) u_de (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .clr (stallD | mispredictM),
    .d   (ent_p0),
    .q   (ent_p1)
  );

  // E -> M
  floprc #(.W($bits(stage_entry_t))) u_em (
    .clk (clk),
    .rst (rst),
    .en  (1'b1),
    .clr (mispredictM),
    .d   (ent_p1),
    .q   (ent_p2)
  );

  assign branchM     = ent_p2.valid;
  assign pred_takeM  = ent_p2.pred;
  assign idx_m       = ent_p2.idx[INDEX_W-1:0];
  assign mispredictM = branchM & (pred_takeM != actual_takeM);
  assign unused_bits = ^{pcF[31:INDEX_W+2], pcF[1:0], ent_p2.idx[IDX_MAX_W-1:INDEX_W]};

  for (genvar g = 0; g < PHT_N; g++) begin : g_pht
    sat_counter2 u_ctr (
      .clk   (clk),
      .rst   (rst),
      .upd   (branchM && (idx_m == INDEX_W'(g))),
      .taken (actual_takeM),
      .state (pht_q[g])
    );
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (branchM)     branch_cnt  <= sat_inc16(branch_cnt);
      if (mispredictM) mispred_cnt <= sat_inc16(mispred_cnt);
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: directed scenarios plus random traffic
// checked against a table-and-pipeline reference model.
module tb_branch_predictor;

  localparam int IW = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pcF;
  logic        stallD, branchD, actual_takeM;
  logic        pred_takeD, pred_takeM, branchM, mispredictM;
  logic [15:0] branch_cnt, mispred_cnt;

  branch_predictor #(.INDEX_W(IW)) dut (
    .clk          (clk),
    .rst          (rst),
    .pcF          (pcF),
    .stallD       (stallD),
    .branchD      (branchD),
    .actual_takeM (actual_takeM),
    .pred_takeD   (pred_takeD),
    .pred_takeM   (pred_takeM),
    .branchM      (branchM),
    .mispredictM  (mispredictM),
    .branch_cnt   (branch_cnt),
    .mispred_cnt  (mispred_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit pred;
    int idx;
  } exp_t;
  exp_t exp_q[$];

  // reference model state
  int pht [1<<IW];
  int d_idx;
  bit e_v, e_p, m_v, m_p;
  int e_idx, m_idx;
  int bcnt, mcnt;
  bit exp_predD, exp_branchM;
  bit mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < (1<<IW); i++) pht[i] = 1;
    d_idx = 0; e_v = 0; e_p = 0; e_idx = 0; m_v = 0; m_p = 0; m_idx = 0;
    bcnt = 0; mcnt = 0; exp_predD = 0; exp_branchM = 0;
    exp_q.delete();
  endtask

  // Called just after a rising edge; drives one cycle and advances the model past the next edge.
  task automatic step(input logic [31:0] pc, input bit st, input bit br, input bit act);
    bit misp, pd;
    pcF = pc; stallD = st; branchD = br; actual_takeM = act;
    pd   = br && (pht[d_idx] >= 2);
    misp = m_v && (m_p != act);
    exp_predD   = pd;
    exp_branchM = m_v;
    if (misp && e_v) void'(exp_q.pop_back());
    if (br && !st && !misp) exp_q.push_back('{pred: pd, idx: d_idx});
    mon_en = 1'b1;
    @(posedge clk);
    #1;
    mon_en = 1'b0;
    if (m_v) begin
      if (act) pht[m_idx] = (pht[m_idx] < 3) ? pht[m_idx] + 1 : 3;
      else     pht[m_idx] = (pht[m_idx] > 0) ? pht[m_idx] - 1 : 0;
      if (bcnt < 65535) bcnt++;
      if (misp && mcnt < 65535) mcnt++;
    end
    if (misp) begin m_v = 0; m_p = 0; m_idx = 0; end
    else begin m_v = e_v; m_p = e_p; m_idx = e_idx; end
    if (st || misp) begin e_v = 0; e_p = 0; e_idx = 0; end
    else begin e_v = br; e_p = pd; e_idx = d_idx; end
    if (misp) d_idx = 0;
    else if (!st) d_idx = int'((pc >> 2) & 32'h3F);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    rst = 1'b0; pcF = 32'h0; stallD = 1'b0; branchD = 1'b1; actual_takeM = 1'b1;
    model_reset();
    #1;
    check("rst_pred_takeD", pred_takeD, 0);
    check("rst_pred_takeM", pred_takeM, 0);
    check("rst_branchM", branchM, 0);
    check("rst_mispredictM", mispredictM, 0);
    check("rst_branch_cnt", branch_cnt, 0);
    check("rst_mispred_cnt", mispred_cnt, 0);
    @(posedge clk);
    #1;
    branchD = 1'b0;
    rst = 1'b1;
  endtask

  // monitor: compares whenever the DUT presents a branch in M
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("pred_takeD", pred_takeD, exp_predD);
        check("branchM", branchM, exp_branchM);
        check("branch_cnt", branch_cnt, bcnt);
        check("mispred_cnt", mispred_cnt, mcnt);
        if (branchM) begin
          if (exp_q.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL sb_underflow: branchM=1 with no expected entry at %0t", $time);
          end else begin
            e = exp_q.pop_front();
            check("pred_takeM", pred_takeM, e.pred);
            check("mispredictM", mispredictM, e.pred != actual_takeM);
          end
        end else begin
          check("pred_takeM_bubble", pred_takeM, 0);
          check("mispredictM_bubble", mispredictM, 0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // first branch, then the same branch taken three times
    do_reset();
    step(32'h100, 0, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(32'h100, 0, 1, 0);
      step(32'h100, 0, 0, 0);
      step(32'h100, 0, 0, 1);
    end
    check("taken3_branch_cnt", branch_cnt, 3);
    check("taken3_mispred_cnt", mispred_cnt, 1);

    // mispredict in M flushes the branches in E and D
    do_reset();
    step(32'h0, 0, 0, 0);
    step(32'h0, 0, 1, 0);
    step(32'h0, 0, 1, 0);
    step(32'h0, 0, 1, 1);
    step(32'h0, 0, 0, 0);
    step(32'h0, 0, 0, 0);
    check("flush_branch_cnt", branch_cnt, 1);
    check("flush_mispred_cnt", mispred_cnt, 1);

    // stall holds the D index and feeds bubbles into E
    do_reset();
    step(32'h14, 0, 0, 0);
    step(32'h28, 1, 1, 0);
    step(32'h28, 1, 1, 0);
    step(32'h28, 0, 1, 0);
    step(32'h0,  0, 0, 0);
    step(32'h0,  0, 0, 0);
    check("stall_branch_cnt", branch_cnt, 1);

    // same-index read in D while M trains it
    do_reset();
    step(32'h14, 0, 0, 0);
    step(32'h14, 0, 1, 0);
    step(32'h14, 0, 0, 0);
    step(32'h14, 0, 1, 1);
    step(32'h14, 0, 0, 0);
    step(32'h14, 0, 1, 0);
    step(32'h14, 0, 0, 0);
    step(32'h14, 0, 0, 1);

    // random traffic
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      step(($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2),
           $urandom_range(0, 4) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // reset mid-stream with branches in flight
    step(32'h0, 0, 1, 0);
    step(32'h0, 0, 1, 0);
    rst = 1'b0; branchD = 1'b1; actual_takeM = 1'b1;
    #1;
    check("midrst_pred_takeD", pred_takeD, 0);
    check("midrst_pred_takeM", pred_takeM, 0);
    check("midrst_branchM", branchM, 0);
    check("midrst_mispredictM", mispredictM, 0);
    check("midrst_branch_cnt", branch_cnt, 0);
    check("midrst_mispred_cnt", mispred_cnt, 0);
    do_reset();

    // misprediction counter saturation
    force dut.mispred_cnt = 16'hFFFF;
    #1;
    release dut.mispred_cnt;
    mcnt = 65535;
    step(32'h0, 0, 0, 0);
    step(32'h0, 0, 1, 0);
    step(32'h0, 0, 0, 0);
    step(32'h0, 0, 0, 1);
    step(32'h0, 0, 0, 0);
    check("sat_mispred_cnt", mispred_cnt, 16'hFFFF);
    check("sat_branch_cnt", branch_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
